// File: rtl/gsim_residual_check.sv
// gsim_residual_check
// Passive checker that sits beside the Gauss-Seidel solver. It snoops the
// 16-sample b load and the 16-sample x result stream. It then recomputes
// r = A*x - b for the fixed banded matrix, one row per cycle. It reports the
// worst |r_i|, the row where it occurs, and whether that value is within TOL.
// The block only drives status outputs, so it never stalls the solve path.
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter int          BW  = 16,
  parameter int          XW  = 32,
  parameter int          AW  = 40,
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  input  logic                 x_valid,
  input  logic signed [XW-1:0] x_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          max_res,
  output logic [3:0]           max_idx,
  output logic                 err
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    WAIT_X = 3'd2,
    LOAD_X = 3'd3,
    CALC   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;

  logic signed [BW-1:0] b_mem [N];
  logic signed [XW-1:0] x_mem [N];

  logic                 b_we;
  logic                 x_we;
  logic [CW-1:0]        b_wr_idx;
  logic [CW-1:0]        x_wr_idx;

  // Neighbours x_{i-3}..x_{i+3} of the current row, sign-extended, 0 off the ends
  logic signed [AW-1:0] nb_p0 [7];
  logic signed [AW-1:0] b_ext_p0;
  logic signed [AW-1:0] s1_p0;
  logic signed [AW-1:0] s2_p0;
  logic signed [AW-1:0] s3_p0;
  logic signed [AW-1:0] res_p0;
  logic [31:0]          abs_p0;
  logic                 better_p0;
  logic [31:0]          best_p0;
  logic [CW-1:0]        best_idx_p0;

  // Running maximum over the rows already processed in CALC
  logic [31:0]          run_max_p1;
  logic [CW-1:0]        run_idx_p1;

  function automatic logic signed [AW-1:0] sext_x(input logic signed [XW-1:0] v);
    return {{(AW-XW){v[XW-1]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] sext_b_q16(input logic signed [BW-1:0] v);
    return {{(AW-BW-16){v[BW-1]}}, v, 16'b0};
  endfunction

  function automatic logic signed [AW-1:0] mul20(input logic signed [AW-1:0] v);
    return (v <<< 4) + (v <<< 2);
  endfunction

  function automatic logic signed [AW-1:0] mul13(input logic signed [AW-1:0] v);
    return (v <<< 3) + (v <<< 2) + v;
  endfunction

  function automatic logic signed [AW-1:0] mul6(input logic signed [AW-1:0] v);
    return (v <<< 2) + (v <<< 1);
  endfunction

  // Magnitude of a full-width residual, clamped to the 32-bit unsigned range
  function automatic logic [31:0] sat_abs(input logic signed [AW-1:0] v);
    logic [AW-1:0] mag;
    mag = v[AW-1] ? $unsigned(-v) : $unsigned(v);
    if (|mag[AW-1:32]) begin
      return 32'hFFFF_FFFF;
    end
    return mag[31:0];
  endfunction

  // Write enables and addresses for the b and x snoop register files
  always_comb begin
    b_we     = in_en && ((state == IDLE) || (state == LOAD_B));
    b_wr_idx = (state == IDLE) ? '0 : cnt;
    x_we     = x_valid && ((state == WAIT_X) || (state == LOAD_X));
    x_wr_idx = (state == WAIT_X) ? '0 : cnt;
  end

  // Sample storage; contents are always fully rewritten before use, so no reset
  always_ff @(posedge clk) begin
    if (b_we) begin
      b_mem[b_wr_idx] <= b_in;
    end
    if (x_we) begin
      x_mem[x_wr_idx] <= x_in;
    end
  end

  // Stage p0: residual of row cnt and its comparison against the running max
  always_comb begin
    int j;
    j = 0;
    for (int k = 0; k < 7; k++) begin
      j        = int'(cnt) + k - 3;
      nb_p0[k] = '0;
      if ((j >= 0) && (j < N)) begin
        nb_p0[k] = sext_x(x_mem[j[CW-1:0]]);
      end
    end
    b_ext_p0    = sext_b_q16(b_mem[cnt]);
    s1_p0       = nb_p0[2] + nb_p0[4];
    s2_p0       = nb_p0[1] + nb_p0[5];
    s3_p0       = nb_p0[0] + nb_p0[6];
    res_p0      = mul20(nb_p0[3]) - mul13(s1_p0) + mul6(s2_p0) - s3_p0 - b_ext_p0;
    abs_p0      = sat_abs(res_p0);
    better_p0   = abs_p0 > run_max_p1;
    best_p0     = better_p0 ? abs_p0 : run_max_p1;
    best_idx_p0 = better_p0 ? cnt : run_idx_p1;
  end

  // Control FSM with registered status outputs; stage p1 running max lives here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      max_res    <= '0;
      max_idx    <= '0;
      err        <= 1'b0;
      run_max_p1 <= '0;
      run_idx_p1 <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            err <= 1'b1;
          end
          if (in_en) begin
            cnt   <= CW'(1);
            state <= LOAD_B;
            busy  <= 1'b1;
          end
        end
        LOAD_B: begin
          if (in_en) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= WAIT_X;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            // A gap in the b stream abandons the partial system
            err   <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT_X: begin
          if (in_en) begin
            err <= 1'b1;
          end
          if (x_valid) begin
            cnt   <= CW'(1);
            state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (x_valid) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              run_max_p1 <= '0;
              run_idx_p1 <= '0;
              state      <= CALC;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          if (in_en || x_valid) begin
            err <= 1'b1;
          end
          run_max_p1 <= best_p0;
          run_idx_p1 <= best_idx_p0;
          if (cnt == LAST) begin
            // Last row: publish the result so it is visible while in DONE
            cnt     <= '0;
            max_res <= best_p0;
            max_idx <= best_idx_p0;
            pass    <= (best_p0 <= TOL);
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (in_en || x_valid) begin
            err <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_residual_check.sv
// Testbench for gsim_residual_check: table of systems with expected
// results, a scoreboard queue consumed on done, and directed protocol,
// tolerance-boundary and reset sequences.
module tb_gsim_residual_check;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_en;
  logic signed [15:0] b_in;
  logic               x_valid;
  logic signed [31:0] x_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [31:0]        max_res;
  logic [3:0]         max_idx;
  logic               err;

  always #5 clk = ~clk;

  gsim_residual_check dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_en   (in_en),
    .b_in    (b_in),
    .x_valid (x_valid),
    .x_in    (x_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .max_res (max_res),
    .max_idx (max_idx),
    .err     (err)
  );

  typedef struct packed {
    logic [15:0][15:0] b;
    logic [15:0][31:0] x;
    logic [31:0]       e_max;
    logic [3:0]        e_idx;
    logic              e_pass;
  } vec_t;

  typedef struct packed {
    logic [31:0] m;
    logic [3:0]  i;
    logic        p;
  } exp_t;

  localparam int NV = 12;

  vec_t        vecs [NV];
  exp_t        sb [$];
  exp_t        mon_e;
  exp_t        me;
  int          checks   = 0;
  int          failures = 0;
  int          err_cnt  = 0;
  int          exp_err  = 0;
  int          done_cnt = 0;
  int          dc;
  logic [31:0] rr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Independent reference: full 16x16 banded product in 64-bit integers
  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint r, a, best, c;
    int     bi, d;
    best = 0;
    bi   = 0;
    for (int i = 0; i < 16; i++) begin
      r = -(longint'($signed(v.b[i])) * 65536);
      for (int j = 0; j < 16; j++) begin
        d = (i > j) ? (i - j) : (j - i);
        case (d)
          0:       c = 20;
          1:       c = -13;
          2:       c = 6;
          3:       c = -1;
          default: c = 0;
        endcase
        r += c * longint'($signed(v.x[j]));
      end
      a = (r < 0) ? -r : r;
      if (a > 64'sh0000_0000_FFFF_FFFF) a = 64'sh0000_0000_FFFF_FFFF;
      if (a > best) begin
        best = a;
        bi   = i;
      end
    end
    e.m = best[31:0];
    e.i = bi[3:0];
    e.p = (best <= 64'sh100);
    return e;
  endfunction

  // Scoreboard consumer and err pulse counter
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 max_res=0x%0h", max_res);
      end else begin
        mon_e = sb.pop_front();
        check("max_res", max_res, mon_e.m);
        check("max_idx", 32'(max_idx), 32'(mon_e.i));
        check("pass", 32'(pass), 32'(mon_e.p));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain; mode 2: extra in_en while waiting for x
  task automatic load(input vec_t v, input int mode);
    for (int k = 0; k < 16; k++) begin
      in_en = 1'b1;
      b_in  = v.b[k];
      tick();
      if (k == 0) check("busy_rise", 32'(busy), 32'd1);
    end
    in_en = 1'b0;
    b_in  = '0;
    if (mode == 2) begin
      in_en = 1'b1;
      b_in  = 16'sh7FFF;
      tick();
      in_en = 1'b0;
      b_in  = '0;
      exp_err++;
      check("err_wait_x_in_en", 32'(err), 32'd1);
    end
    for (int k = 0; k < 16; k++) begin
      x_valid = 1'b1;
      x_in    = v.x[k];
      tick();
    end
    x_valid = 1'b0;
    x_in    = '0;
  endtask

  // mode 1: in_en during the done cycle (must be rejected)
  task automatic run_system(input vec_t v, input int mode);
    int lat;
    load(v, mode);
    lat = 0;
    for (int k = 1; (k <= 40) && (lat == 0); k++) begin
      @(negedge clk);
      if (done === 1'b1) lat = k;
      else tick();
    end
    check("done_latency", 32'(lat), 32'd17);
    if (mode == 1) begin
      in_en = 1'b1;
      b_in  = 16'sh1234;
      exp_err++;
    end
    tick();
    in_en = 1'b0;
    b_in  = '0;
    check("busy_after_done", 32'(busy), 32'd0);
    if (mode == 1) check("err_in_done", 32'(err), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_max_res"}, max_res, 32'd0);
    check({tag, "_max_idx"}, 32'(max_idx), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_en   = 1'b0;
    x_valid = 1'b0;
    b_in    = '0;
    x_in    = '0;

    for (int i = 0; i < NV; i++) vecs[i] = '0;
    // 0: zero system
    vecs[0].e_max = 32'h0; vecs[0].e_idx = 4'd0; vecs[0].e_pass = 1'b1;
    // 1: column of A as b, unit x_0
    vecs[1].b[0] = 16'd20; vecs[1].b[1] = 16'hFFF3; vecs[1].b[2] = 16'd6; vecs[1].b[3] = 16'hFFFF;
    vecs[1].x[0] = 32'h0001_0000;
    vecs[1].e_max = 32'h0; vecs[1].e_idx = 4'd0; vecs[1].e_pass = 1'b1;
    // 2: unit vector error
    vecs[2].x[0] = 32'h0001_0000;
    vecs[2].e_max = 32'h0014_0000; vecs[2].e_idx = 4'd0; vecs[2].e_pass = 1'b0;
    // 3: saturation
    for (int k = 0; k < 16; k++) begin
      vecs[3].x[k] = 32'h7FFF_FFFF;
      vecs[3].b[k] = 16'h8000;
    end
    vecs[3].e_max = 32'hFFFF_FFFF; vecs[3].e_idx = 4'd0; vecs[3].e_pass = 1'b0;
    // 4: max exactly TOL (20*11 + 6*6 = 256 on row 5)
    vecs[4].x[5] = 32'd11; vecs[4].x[7] = 32'd6;
    vecs[4].e_max = 32'h100; vecs[4].e_idx = 4'd5; vecs[4].e_pass = 1'b1;
    // 5: just above TOL (20*13 = 260)
    vecs[5].x[5] = 32'd13;
    vecs[5].e_max = 32'h104; vecs[5].e_idx = 4'd5; vecs[5].e_pass = 1'b0;
    // 6: tie between rows 5 and 10 keeps row 5
    vecs[6].x[5] = 32'h0001_0000; vecs[6].x[10] = 32'h0001_0000;
    vecs[6].e_max = 32'h0014_0000; vecs[6].e_idx = 4'd5; vecs[6].e_pass = 1'b0;
    // 7: negative residual from b only
    vecs[7].b[3] = 16'd1;
    vecs[7].e_max = 32'h0001_0000; vecs[7].e_idx = 4'd3; vecs[7].e_pass = 1'b0;
    // 8: last row, upper neighbours off the end
    vecs[8].x[15] = 32'h0001_0000;
    vecs[8].e_max = 32'h0014_0000; vecs[8].e_idx = 4'd15; vecs[8].e_pass = 1'b0;
    // 9..11: random, checked against the reference model
    for (int i = 9; i < NV; i++) begin
      for (int k = 0; k < 16; k++) begin
        rr = $urandom;
        if (i == 11) begin
          vecs[i].x[k] = rr;
          rr = $urandom;
          vecs[i].b[k] = rr[15:0];
        end else begin
          vecs[i].x[k] = {{11{rr[20]}}, rr[20:0]};
          vecs[i].b[k] = 16'($urandom_range(0, 15)) - 16'd8;
        end
      end
      me = model(vecs[i]);
      vecs[i].e_max  = me.m;
      vecs[i].e_idx  = me.i;
      vecs[i].e_pass = me.p;
    end

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // x_valid while idle is a violation
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    exp_err++;
    check("err_idle_x_valid", 32'(err), 32'd1);
    check("busy_idle_x_valid", 32'(busy), 32'd0);
    tick();
    check("err_one_cycle", 32'(err), 32'd0);

    // Table: back-to-back systems, each started in the first idle cycle
    for (int i = 0; i < NV; i++) begin
      sb.push_back('{m: vecs[i].e_max, i: vecs[i].e_idx, p: vecs[i].e_pass});
      run_system(vecs[i], (i == 5) ? 1 : ((i == 6) ? 2 : 0));
    end

    // in_en drops after 7 samples
    for (int k = 0; k < 7; k++) begin
      in_en = 1'b1;
      b_in  = 16'(k);
      tick();
    end
    in_en = 1'b0;
    b_in  = '0;
    check("gap_err_before", 32'(err), 32'd0);
    check("gap_busy_before", 32'(busy), 32'd1);
    tick();
    exp_err++;
    check("gap_err", 32'(err), 32'd1);
    check("gap_busy", 32'(busy), 32'd0);
    tick();
    check("gap_err_clear", 32'(err), 32'd0);
    sb.push_back('{m: vecs[2].e_max, i: vecs[2].e_idx, p: vecs[2].e_pass});
    run_system(vecs[2], 0);

    // Leave pass=1 and a nonzero result, then reset in the middle of CALC
    sb.push_back('{m: vecs[4].e_max, i: vecs[4].e_idx, p: vecs[4].e_pass});
    run_system(vecs[4], 0);
    dc = done_cnt;
    load(vecs[3], 0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("mid_calc_reset");
    repeat (30) tick();
    check("no_done_after_reset", 32'(done_cnt), 32'(dc));

    // Recovery after reset
    sb.push_back('{m: vecs[8].e_max, i: vecs[8].e_idx, p: vecs[8].e_pass});
    run_system(vecs[8], 0);

    check("err_total", 32'(err_cnt), 32'(exp_err));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
